fir_decimator_fifo: RTL and testbench
=====================================

// Module: fir_decimator_fifo
// PURPOSE
//   Downstream consumer of the 12-bit FIR filter output. Averages each block of
//   2**DECIM_LOG2 consecutive valid samples into one output sample (boxcar
//   decimation). Queues results in a small FIFO and presents them on a
//   valid/ready interface to the next stage.
// PARAMETERS
//   DATA_W          12  sample width, signed two's complement, input and output
//   DECIM_LOG2      2   log2 of decimation factor D (D=4 by default); must be >=1
//   FIFO_DEPTH_LOG2 2   log2 of output FIFO depth (4 entries by default)
// PORTS
//   clock       in   1                  rising-edge clock
//   reset       in   1                  asynchronous, active-high reset
//   data_in     in   DATA_W             signed sample from FIR filter
//   in_valid    in   1                  data_in valid; tie high for a free-running FIR
//   data_out    out  DATA_W             signed head-of-FIFO sample; 0 when FIFO empty
//   out_valid   out  1                  FIFO non-empty
//   out_ready   in   1                  consumer accepts data_out when out_valid & out_ready
//   fifo_level  out  FIFO_DEPTH_LOG2+1  number of entries held, 0..2**FIFO_DEPTH_LOG2
//   overflow    out  1                  sticky; a result was dropped because the FIFO was full
// BEHAVIOUR
//   - Reset (async, active-high): acc=0, phase=0, FIFO pointers and level=0,
//     overflow=0, out_valid=0, data_out=0. Any partial accumulation is discarded.
//   - Accumulator: signed, DATA_W+DECIM_LOG2 bits; cannot overflow.
//     phase counts 0..D-1 and advances only on in_valid.
//   - Edge with in_valid & phase<D-1: acc <= acc + data_in; phase++.
//   - Edge with in_valid & phase==D-1: sum = acc + data_in;
//     result = sum >>> DECIM_LOG2 (arithmetic shift, floor). Result is pushed to
//     the FIFO; acc <= 0; phase <= 0. Result always fits DATA_W, no saturation.
//   - in_valid=0: acc and phase hold.
//   - Latency: result is visible on data_out/out_valid in the cycle after the edge
//     that captured the D-th sample, provided the FIFO was empty.
//   - FIFO: registered storage; data_out = mem[rd_ptr] when non-empty, else 0.
//     A pop occurs on an edge where out_valid & out_ready.
//   - A push is accepted if the FIFO is not full, or if a pop occurs on the same edge.
//     Full with simultaneous push and pop: level unchanged, no drop.
//   - Push while full with no pop: result dropped, overflow <= 1.
//     overflow stays set until reset.
//   - Simultaneous push and pop when empty: impossible (out_valid=0); push only.
//   - Pointers wrap modulo depth. fifo_level = pushes - pops, never exceeds depth.
// CONFIGURATION
//   ROUND_EN defined: result = (sum + 2**(DECIM_LOG2-1)) >>> DECIM_LOG2
//     (round half up). The adder is one bit wider, so sum 4*2047 still yields 2047.
//   ROUND_EN undefined: truncating floor shift as above. All else identical.
// TESTING (D=4, depth 4, out_ready=1 unless stated)
//   1. data_in 10,20,30,40 then 100x4 -> data_out 25 then 100. out_valid high one
//      cycle each, the cycle after the 4th sample edge.
//   2. data_in -1,-1,-1,-2 (sum -5) -> data_out -2 without ROUND_EN, -1 with ROUND_EN.
//   3. 4x 2047 -> 2047; 4x -2048 -> -2048, in both configurations.
//   4. out_ready=0, 20 samples of 5 -> fifo_level=4, 5th result dropped, overflow=1.
//      Then out_ready=1 -> four outputs of 5, out_valid=0, overflow still 1.
//   5. FIFO full, out_ready=1 on the same edge as a push -> level stays 4,
//      overflow stays 0, output order preserved.
//   6. Two samples of 100, assert reset for 1 cycle, then 4 samples of 8 ->
//      single output of 8, no stale 100 data emitted.

Source files
------------

// File: rtl/fir_decimator_fifo_if.sv
// Stream bundle between the FIR filter, the boxcar decimator and its consumer.
// The master modport is the surrounding system; the slave modport is the decimator.
interface fir_decimator_fifo_if #(
  parameter int DATA_W          = 12,
  parameter int FIFO_DEPTH_LOG2 = 2
);
  logic signed [DATA_W-1:0]    data_in;
  logic                        in_valid;
  logic signed [DATA_W-1:0]    data_out;
  logic                        out_valid;
  logic                        out_ready;
  logic [FIFO_DEPTH_LOG2:0]    fifo_level;
  logic                        overflow;

  modport master (
    output data_in, in_valid, out_ready,
    input  data_out, out_valid, fifo_level, overflow
  );

  modport slave (
    input  data_in, in_valid, out_ready,
    output data_out, out_valid, fifo_level, overflow
  );
endinterface

// File: rtl/fir_decimator_fifo.sv
// Boxcar decimator: averages each block of 2**DECIM_LOG2 valid samples and queues
// the results in a small FIFO. Define ROUND_EN for round-half-up instead of floor.
module fir_decimator_fifo #(
  parameter int DATA_W          = 12,
  parameter int DECIM_LOG2      = 2,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                clock,
  input  logic                reset,
  fir_decimator_fifo_if.slave bus
);
  localparam int ACC_W = DATA_W + DECIM_LOG2;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int LVL_W = FIFO_DEPTH_LOG2 + 1;

  localparam logic [DECIM_LOG2-1:0]      PHASE_ONE  = 1;
  localparam logic [DECIM_LOG2-1:0]      PHASE_LAST = '1;
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = 1;
  localparam logic [LVL_W-1:0]           LVL_ONE    = 1;
  localparam logic [LVL_W-1:0]           LVL_FULL   = LVL_W'(DEPTH);

`ifdef ROUND_EN
  // One extra bit keeps the bias addition exact at the positive rail.
  function automatic logic signed [DATA_W-1:0] scale(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W:0] w;
    w = $signed({s[ACC_W-1], s}) + $signed((ACC_W+1)'(1 << (DECIM_LOG2 - 1)));
    return DATA_W'(w >>> DECIM_LOG2);
  endfunction
`else
  function automatic logic signed [DATA_W-1:0] scale(input logic signed [ACC_W-1:0] s);
    return DATA_W'(s >>> DECIM_LOG2);
  endfunction
`endif

  // Stage p0: block accumulation
  logic signed [ACC_W-1:0]  acc_p0;
  logic [DECIM_LOG2-1:0]    phase_p0;
  logic signed [ACC_W-1:0]  sum_p0;
  logic signed [DATA_W-1:0] result_p0;
  logic                     vld_p0;

  assign sum_p0    = acc_p0 + $signed({{DECIM_LOG2{bus.data_in[DATA_W-1]}}, bus.data_in});
  assign vld_p0    = bus.in_valid && (phase_p0 == PHASE_LAST);
  assign result_p0 = scale(sum_p0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_p0   <= '0;
      phase_p0 <= '0;
    end else if (bus.in_valid) begin
      if (phase_p0 == PHASE_LAST) begin
        acc_p0   <= '0;
        phase_p0 <= '0;
      end else begin
        acc_p0   <= sum_p0;
        phase_p0 <= phase_p0 + PHASE_ONE;
      end
    end
  end

  // Stage p1: result FIFO
  logic signed [DATA_W-1:0]   mem_p1 [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_p1;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_p1;
  logic [LVL_W-1:0]           level_p1;
  logic                       overflow_p1;
  logic                       vld_p1;
  logic                       full;
  logic                       pop;
  logic                       push_ok;

  assign vld_p1  = (level_p1 != '0);
  assign full    = (level_p1 == LVL_FULL);
  assign pop     = vld_p1 && bus.out_ready;
  // A full FIFO still takes the new result when the head leaves on the same edge.
  assign push_ok = vld_p0 && (!full || pop);

  always_ff @(posedge clock) begin
    if (push_ok) mem_p1[wr_ptr_p1] <= result_p0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_p1   <= '0;
      rd_ptr_p1   <= '0;
      level_p1    <= '0;
      overflow_p1 <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_p1 <= wr_ptr_p1 + PTR_ONE;
      if (pop)     rd_ptr_p1 <= rd_ptr_p1 + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   level_p1 <= level_p1 + LVL_ONE;
        2'b01:   level_p1 <= level_p1 - LVL_ONE;
        default: level_p1 <= level_p1;
      endcase
      if (vld_p0 && !push_ok) overflow_p1 <= 1'b1;
    end
  end

  assign bus.out_valid  = vld_p1;
  assign bus.data_out   = vld_p1 ? mem_p1[rd_ptr_p1] : '0;
  assign bus.fifo_level = level_p1;
  assign bus.overflow   = overflow_p1;
endmodule

// File: tb/tb_fir_decimator_fifo.sv
// Directed bench for fir_decimator_fifo: a queue-based reference model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_fir_decimator_fifo;
  localparam int DATA_W = 12;
  localparam int DECIM  = 4;
  localparam int DEPTH  = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  fir_decimator_fifo_if #(.DATA_W(DATA_W), .FIFO_DEPTH_LOG2(2)) bus ();

  fir_decimator_fifo #(.DATA_W(DATA_W), .DECIM_LOG2(2), .FIFO_DEPTH_LOG2(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: the pending block as a list of samples, the FIFO as a queue.
  int m_block[$];
  int m_fifo[$];
  bit m_ovf = 1'b0;

  function automatic int block_mean(input int s);
    int n;
    int q;
`ifdef ROUND_EN
    n = s + DECIM / 2;
`else
    n = s;
`endif
    q = n / DECIM;
    if ((n % DECIM != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_block.delete();
      m_fifo.delete();
      m_ovf = 1'b0;
    end else begin
      if (m_fifo.size() > 0 && bus.out_ready) void'(m_fifo.pop_front());
      if (bus.in_valid) begin
        m_block.push_back(int'(bus.data_in));
        if (m_block.size() == DECIM) begin
          int total;
          total = 0;
          foreach (m_block[i]) total += m_block[i];
          if (m_fifo.size() < DEPTH) m_fifo.push_back(block_mean(total));
          else m_ovf = 1'b1;
          m_block.delete();
        end
      end
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clock) begin
    if (cmp_en) begin
      check("model_out_valid", int'(bus.out_valid), (m_fifo.size() > 0) ? 1 : 0);
      check("model_data_out", int'(bus.data_out), (m_fifo.size() > 0) ? m_fifo[0] : 0);
      check("model_fifo_level", int'(bus.fifo_level), m_fifo.size());
      check("model_overflow", int'(bus.overflow), int'(m_ovf));
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic feed(input int v);
    bus.in_valid = 1'b1;
    bus.data_in  = DATA_W'(v);
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic feed_n(input int v, input int n);
    for (int k = 0; k < n; k++) feed(v);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    cyc();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b1;
    cyc();
    cmp_en = 1'b1;
    cyc();
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_data_out", int'(bus.data_out), 0);
    check("reset_level", int'(bus.fifo_level), 0);
    check("reset_overflow", int'(bus.overflow), 0);
    reset = 1'b0;
    idle();

    // Averages 25 then 100; a gap in in_valid must not disturb the block.
    feed(10); feed(20); idle(); feed(30);
    check("t1_not_yet", int'(bus.out_valid), 0);
    feed(40);
    check("t1_first_valid", int'(bus.out_valid), 1);
    check("t1_first_value", int'(bus.data_out), 25);
    feed(100);
    check("t1_one_cycle", int'(bus.out_valid), 0);
    feed_n(100, 3);
    check("t1_second_value", int'(bus.data_out), 100);
    idle();
    check("t1_drained", int'(bus.out_valid), 0);

    // Negative sum -5: floor gives -2, round-half-up gives -1.
    feed(-1); feed(-1); feed(-1); feed(-2);
`ifdef ROUND_EN
    check("t2_neg_round", int'(bus.data_out), -1);
`else
    check("t2_neg_floor", int'(bus.data_out), -2);
`endif
    idle();

    // Rails survive in both configurations.
    feed_n(2047, 4);
    check("t3_pos_rail", int'(bus.data_out), 2047);
    idle();
    feed_n(-2048, 4);
    check("t3_neg_rail", int'(bus.data_out), -2048);
    idle();

    // Consumer stalled: four results held, the fifth dropped.
    bus.out_ready = 1'b0;
    feed_n(5, 20);
    check("t4_level_full", int'(bus.fifo_level), 4);
    check("t4_overflow_set", int'(bus.overflow), 1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t4_drain_value", int'(bus.data_out), 5);
      idle();
    end
    check("t4_empty", int'(bus.out_valid), 0);
    check("t4_overflow_sticky", int'(bus.overflow), 1);

    // Full FIFO with push and pop on the same edge loses nothing.
    pulse_reset();
    check("t5_reset_clears_ovf", int'(bus.overflow), 0);
    bus.out_ready = 1'b0;
    for (int v = 1; v <= 4; v++) feed_n(v, 4);
    check("t5_level_full", int'(bus.fifo_level), 4);
    feed_n(5, 3);
    bus.out_ready = 1'b1;
    feed(5);
    check("t5_level_kept", int'(bus.fifo_level), 4);
    check("t5_no_overflow", int'(bus.overflow), 0);
    for (int v = 2; v <= 5; v++) begin
      check("t5_order", int'(bus.data_out), v);
      idle();
    end
    check("t5_empty", int'(bus.fifo_level), 0);

    // Reset mid-block discards the partial sum.
    feed(100); feed(100);
    pulse_reset();
    feed_n(8, 3);
    check("t6_no_stale", int'(bus.out_valid), 0);
    feed(8);
    check("t6_value", int'(bus.data_out), 8);
    check("t6_level", int'(bus.fifo_level), 1);
    idle();
    check("t6_single_output", int'(bus.out_valid), 0);
    idle();

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
